// File: rtl/retire_trace_buffer_if.sv
// Retire trace buffer bus bundle.
// Groups the writeback record, capture control, read port and status outputs.
//   master : drives the writeback record, capture control and read requests; observes read data and status
//   slave  : the trace buffer itself
interface retire_trace_buffer_if #(
    parameter int ADDR_W = 4
);
    // writeback record
    logic              i_valid;
    logic [31:0]       i_pc;
    logic [31:0]       i_instr;
    logic [4:0]        i_rd;
    logic [31:0]       i_rd_data;
    logic              i_reg_write_en;
    // capture control
    logic              i_arm;
    logic              i_abort;
    logic              i_trig_en;
    logic [31:0]       i_trig_pc;
    // read port
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_valid;
    logic              o_rd_err;
    logic [31:0]       o_rd_pc;
    logic [31:0]       o_rd_instr;
    logic [4:0]        o_rd_rd;
    logic [31:0]       o_rd_data;
    logic              o_rd_we;
    // status
    logic              o_armed;
    logic              o_done;
    logic [ADDR_W:0]   o_count;
    logic [ADDR_W-1:0] o_trig_idx;

    modport master (
        output i_valid, i_pc, i_instr, i_rd, i_rd_data, i_reg_write_en,
        output i_arm, i_abort, i_trig_en, i_trig_pc,
        output i_rd_req, i_rd_addr,
        input  o_rd_valid, o_rd_err, o_rd_pc, o_rd_instr, o_rd_rd, o_rd_data, o_rd_we,
        input  o_armed, o_done, o_count, o_trig_idx
    );

    modport slave (
        input  i_valid, i_pc, i_instr, i_rd, i_rd_data, i_reg_write_en,
        input  i_arm, i_abort, i_trig_en, i_trig_pc,
        input  i_rd_req, i_rd_addr,
        output o_rd_valid, o_rd_err, o_rd_pc, o_rd_instr, o_rd_rd, o_rd_data, o_rd_we,
        output o_armed, o_done, o_count, o_trig_idx
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer.
// Captures retired-instruction records into a circular buffer while armed,
// freezes POST_COUNT retires after a PC-match trigger, and serves the frozen
// window oldest-first through a registered read port.
// Ports:
//   i_clk  : clock, all logic on posedge
//   i_rst  : synchronous active-high reset
//   bus    : slave side of retire_trace_buffer_if (record in, control, read port, status)
//
// state  | meaning
// IDLE   | not capturing, buffer not readable
// ARMED  | capturing, PC-match trigger live
// POST   | trigger seen, capturing the post-trigger retires
// DONE   | frozen, buffer readable
module retire_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int POST_COUNT = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    retire_trace_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        we;
    } rec_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_C  = ADDR_W'(POST_COUNT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_slot_q, trig_slot_d;
    logic              armed_q, armed_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    rec_t              rd_rec_q, rd_rec_d;

    rec_t              mem_q [DEPTH];
    logic              wr_en;
    rec_t              wr_rec;

    logic              trig_hit;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] rd_phys;
    logic              rd_legal;

    assign wr_rec   = '{pc: bus.i_pc, instr: bus.i_instr, rd: bus.i_rd,
                        rd_data: bus.i_rd_data, we: bus.i_reg_write_en};
    assign trig_hit = bus.i_valid & bus.i_trig_en & (bus.i_pc == bus.i_trig_pc);

    // Until the buffer has wrapped, slot 0 holds the oldest record.
    assign oldest   = (count_q == DEPTH_C) ? wr_ptr_q : '0;
    assign rd_phys  = oldest + bus.i_rd_addr;
    assign rd_legal = (state_q == DONE) && ({1'b0, bus.i_rd_addr} < count_q);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        trig_slot_d = trig_slot_q;
        wr_en       = 1'b0;

        if (bus.i_abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.i_arm) begin
                        state_d  = ARMED;
                        wr_ptr_d = '0;
                        count_d  = '0;
                    end
                end
                ARMED: begin
                    if (bus.i_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q != DEPTH_C) count_d = count_q + 1'b1;
                        if (trig_hit) begin
                            trig_slot_d = wr_ptr_q;
                            if (POST_COUNT == 0) begin
                                state_d = DONE;
                            end else begin
                                state_d    = POST;
                                post_cnt_d = POST_C;
                            end
                        end
                    end
                end
                POST: begin
                    if (bus.i_valid) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (count_q != DEPTH_C) count_d = count_q + 1'b1;
                        if (post_cnt_q == ADDR_W'(1)) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        armed_d = (state_d == ARMED) || (state_d == POST);
        done_d  = (state_d == DONE);

        rd_valid_d = bus.i_rd_req;
        rd_err_d   = bus.i_rd_req & ~rd_legal;
        rd_rec_d   = rd_rec_q;
        if (bus.i_rd_req) rd_rec_d = rd_legal ? mem_q[rd_phys] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            trig_slot_q <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_rec_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            trig_slot_q <= trig_slot_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            rd_rec_q    <= rd_rec_d;
        end
    end

    // Storage is not reset; count gates what is readable.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign bus.o_armed    = armed_q;
    assign bus.o_done     = done_q;
    assign bus.o_count    = count_q;
    assign bus.o_trig_idx = (state_q == DONE) ? (trig_slot_q - oldest) : '0;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_rd_err   = rd_err_q;
    assign bus.o_rd_pc    = rd_rec_q.pc;
    assign bus.o_rd_instr = rd_rec_q.instr;
    assign bus.o_rd_rd    = rd_rec_q.rd;
    assign bus.o_rd_data  = rd_rec_q.rd_data;
    assign bus.o_rd_we    = rd_rec_q.we;

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesizable capture of retired-instruction records at the writeback stage boundary; the hardware counterpart of the simulation-only pipeline print.
- Consumes the writeback record (PC, instruction, rd, rd_data, reg write enable) every retire cycle into a circular buffer.
- Freezes on a PC-match trigger after a programmable number of post-trigger retires; the frozen window is read back oldest-first through a registered read port.

Parameters:
DEPTH, 16, number of trace entries; power of two, at least 4
ADDR_W, 4, log2(DEPTH)
POST_COUNT, 8, retires captured after the trigger record; 0 to DEPTH-1

Ports:
i_clk  input  1  clock; all logic on posedge
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  writeback record valid this cycle (one instruction retired)
i_pc  input  32  PC of retiring instruction
i_instr  input  32  instruction word
i_rd  input  5  destination register index
i_rd_data  input  32  writeback data
i_reg_write_en  input  1  writeback enable
i_arm  input  1  pulse: start new capture
i_abort  input  1  pulse: cancel capture, return to IDLE
i_trig_en  input  1  enable PC-match trigger
i_trig_pc  input  32  trigger PC
i_rd_req  input  1  read request
i_rd_addr  input  ADDR_W  read index; 0 is the oldest captured entry
o_rd_valid  output  1  read data valid, 1 cycle after i_rd_req
o_rd_err  output  1  read out of range or not in DONE; qualified by o_rd_valid
o_rd_pc  output  32  read record PC
o_rd_instr  output  32  read record instruction
o_rd_rd  output  5  read record rd
o_rd_data  output  32  read record rd_data
o_rd_we  output  1  read record reg_write_en
o_armed  output  1  state is ARMED or POST
o_done  output  1  state is DONE
o_count  output  ADDR_W+1  valid entries, 0..DEPTH
o_trig_idx  output  ADDR_W  read index of the trigger record, valid in DONE

Behaviour:
- Reset values: state IDLE; wr_ptr, count, post_cnt, trigger slot all 0; every output 0. Reset mid-capture discards the capture. Storage contents need no reset.
- States: IDLE, ARMED, POST, DONE. o_armed and o_done are registered decodes of state.
- IDLE: i_valid ignored. On i_arm: ARMED; clear wr_ptr and count.
- DONE: i_valid ignored. On i_arm: ARMED with the same clearing; the buffer is no longer readable.
- ARMED/POST: i_arm ignored.
- i_abort in any state: IDLE next cycle; clear count. i_abort beats a simultaneous i_arm.
- ARMED write path:
  - Each i_valid writes {pc, instr, rd, rd_data, we} at wr_ptr.
  - wr_ptr increments modulo DEPTH; count saturates at DEPTH.
- Trigger:
  - Fires when i_valid & i_trig_en & (i_pc == i_trig_pc) in ARMED.
  - The triggering record is written and its slot is latched.
  - Next state: DONE if POST_COUNT==0, else POST with post_cnt = POST_COUNT.
  - Trigger is evaluated only in ARMED; further PC matches in POST are ordinary records.
- POST: each i_valid writes as in ARMED and decrements post_cnt. The write that takes post_cnt to 0 moves the state to DONE on the same edge.
- Wrap: once count==DEPTH, the oldest entry is overwritten. The oldest slot is wr_ptr when count==DEPTH, else 0.
- Read path:
  - Physical slot = (oldest + i_rd_addr) mod DEPTH.
  - Latency 1: o_rd_valid registered from i_rd_req; data registered.
  - Legal reads: state DONE and i_rd_addr < count. Otherwise o_rd_err=1 and data fields return 0.
  - Reads in DONE have no side effects. Back-to-back reads are supported at one per cycle.
- o_trig_idx = (trigger slot - oldest) mod DEPTH, computed in DONE.
- A POST_COUNT that overruns the pre-trigger history leaves o_trig_idx at the correct position of the surviving trigger record, since POST_COUNT < DEPTH.

Test Plan:
- Reset mid-POST -> next cycle: o_armed=0, o_done=0, o_count=0, o_rd_valid=0.
- Arm, retire 5 records at PCs 0x00,0x04..0x10, trigger at 0x08, POST_COUNT=8, total 11 retires -> o_done=1, o_count=11, o_trig_idx=2, read 0 gives pc 0x00, read 10 gives pc 0x28.
- Retire 40 records at PCs 0x100 + 4k, trigger at 0x100+4*30 (DEPTH=16, POST_COUNT=8) -> DONE after record 38, o_count=16, read 0 pc 0x15C (k=23), o_trig_idx=7, records 39 and up ignored.
- Trigger with POST_COUNT=0 on the 3rd retire -> DONE the same edge, o_count=3, o_trig_idx=2.
- In DONE, read i_rd_addr=12 with o_count=11 -> o_rd_valid=1, o_rd_err=1, data 0. A read issued in ARMED -> o_rd_err=1.
- i_arm and i_abort asserted together in ARMED -> IDLE, o_count=0; a later i_arm with i_valid gaps -> only cycles with i_valid=1 are counted.
